// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle datapath and its controller.
// slave = controller side (decodes instruction fields, drives strobes/selects); master = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PC_write;
  logic       adr_src;
  logic       mem_write;
  logic       IR_write;
  logic [1:0] result_src;
  logic [1:0] ALU_srcA;
  logic [1:0] ALU_srcB;
  logic [2:0] ALU_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PC_write, adr_src, mem_write, IR_write, result_src, ALU_srcA, ALU_srcB,
           ALU_control, imm_src, reg_write, illegal, state
  );

  modport master (
    output op, funct3, funct7b5, zero,
    input  PC_write, adr_src, mem_write, IR_write, result_src, ALU_srcA, ALU_srcB,
           ALU_control, imm_src, reg_write, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32 subset; lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles.
// No backpressure: one state per clock; strobes are forced low while rst_n is asserted.
module multicycle_controller (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.slave        bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  ctrl_t      r_ctrl;
  state_t     w_next;
  logic       w_op_legal;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;

  always_comb begin
    w_op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: w_op_legal = 1'b1;
      default:                                  w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so every select/strobe comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_of(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
    end
  end

  always_comb begin
    w_alu_control = 3'b010;
    case (r_ctrl.alu_op)
      2'b00: w_alu_control = 3'b010;
      2'b01: w_alu_control = 3'b110;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_alu_control = (bus.op[5] & bus.funct7b5) ? 3'b110 : 3'b010;
          3'b010:  w_alu_control = 3'b111;
          3'b110:  w_alu_control = 3'b001;
          3'b111:  w_alu_control = 3'b000;
          default: w_alu_control = 3'b010;
        endcase
      end
      default: w_alu_control = 3'b010;
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (bus.op)
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // The reset flop value carries FETCH's strobes, so gate them until reset releases.
  assign bus.PC_write    = rst_n & (r_ctrl.pc_update | (r_ctrl.branch & bus.zero));
  assign bus.IR_write    = rst_n & r_ctrl.ir_write;
  assign bus.mem_write   = rst_n & r_ctrl.mem_write;
  assign bus.reg_write   = rst_n & r_ctrl.reg_write;
  assign bus.adr_src     = r_ctrl.adr_src;
  assign bus.result_src  = r_ctrl.result_src;
  assign bus.ALU_srcA    = r_ctrl.alu_src_a;
  assign bus.ALU_srcB    = r_ctrl.alu_src_b;
  assign bus.ALU_control = w_alu_control;
  assign bus.imm_src     = w_imm_src;
  assign bus.illegal     = (r_state == S_DECODE) & ~w_op_legal;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, corner sequences and random instructions vs a reference model.
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ir, adr, mw, rw, pcu, br;
    logic [1:0] rsrc, sa, sb, aop;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic [2:0] alu;
    logic       pcw;
  } vec_t;

  exp_t tbl[11];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 11; i++) tbl[i] = '{default: '0};
    tbl[0].ir = 1; tbl[0].sb = 2'b10; tbl[0].rsrc = 2'b10; tbl[0].pcu = 1;
    tbl[1].sa = 2'b01; tbl[1].sb = 2'b01;
    tbl[2].sa = 2'b10; tbl[2].sb = 2'b01;
    tbl[3].adr = 1;
    tbl[4].rsrc = 2'b01; tbl[4].rw = 1;
    tbl[5].adr = 1; tbl[5].mw = 1;
    tbl[6].sa = 2'b10; tbl[6].aop = 2'b10;
    tbl[7].rw = 1;
    tbl[8].sa = 2'b10; tbl[8].sb = 2'b01; tbl[8].aop = 2'b10;
    tbl[9].sa = 2'b01; tbl[9].sb = 2'b10; tbl[9].pcu = 1;
    tbl[10].sa = 2'b10; tbl[10].aop = 2'b01; tbl[10].br = 1;
  endtask

  function automatic int ref_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int ref_state(input logic [6:0] o, input int k);
    int path[5];
    case (o)
      7'b0000011: path = '{0, 1, 2, 3, 4};
      7'b0100011: path = '{0, 1, 2, 5, 0};
      7'b0110011: path = '{0, 1, 6, 7, 0};
      7'b0010011: path = '{0, 1, 8, 7, 0};
      7'b1101111: path = '{0, 1, 9, 7, 0};
      7'b1100011: path = '{0, 1, 10, 0, 0};
      default:    path = '{0, 1, 0, 0, 0};
    endcase
    return path[k];
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (aop == 2'b00) return 3'b010;
    if (aop == 2'b01) return 3'b110;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b110 : 3'b010;
      3'b010:  return 3'b111;
      3'b110:  return 3'b001;
      3'b111:  return 3'b000;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check_cycle(input int st, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
    exp_t e;
    e = tbl[st];
    chk("state",       16'(bus.state),       16'(st));
    chk("PC_write",    16'(bus.PC_write),    16'(e.pcu | (e.br & z)));
    chk("IR_write",    16'(bus.IR_write),    16'(e.ir));
    chk("mem_write",   16'(bus.mem_write),   16'(e.mw));
    chk("reg_write",   16'(bus.reg_write),   16'(e.rw));
    chk("adr_src",     16'(bus.adr_src),     16'(e.adr));
    chk("result_src",  16'(bus.result_src),  16'(e.rsrc));
    chk("ALU_srcA",    16'(bus.ALU_srcA),    16'(e.sa));
    chk("ALU_srcB",    16'(bus.ALU_srcB),    16'(e.sb));
    chk("ALU_control", 16'(bus.ALU_control), 16'(alu_ref(e.aop, o, f3, f7)));
    chk("imm_src",     16'(bus.imm_src),     16'(imm_ref(o)));
    chk("illegal",     16'(bus.illegal),     16'((st == 1) && (ref_len(o) == 2)));
  endtask

  // Entered just after a rising edge with the FSM in FETCH; leaves the same way.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, output int lat, output logic [2:0] alu_x,
                           output logic pcw_last);
    int len;
    len        = ref_len(o);
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
    lat      = 0;
    alu_x    = 3'b000;
    pcw_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < len) check_cycle(ref_state(o, c), o, f3, f7, z);
      if (bus.state == 4'd6 || bus.state == 4'd8) alu_x = bus.ALU_control;
      pcw_last = bus.PC_write;
      @(posedge clk);
      #1;
      lat++;
      if (bus.state == 4'd0) break;
    end
    chk("back_to_fetch", 16'(bus.state), 16'd0);
    chk("latency", 16'(lat), 16'(len));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [2:0] alu_x;
    logic       pcw;
    logic [6:0] o;
    bit         found;

    total = 0;
    bad   = 0;
    init_model();
    vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0};
    vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b110, 1'b0};
    vecs[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b010, 1'b0};
    vecs[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b111, 1'b0};
    vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b001, 1'b0};
    vecs[6]  = '{7'b0110011, 3'b111, 1'b1, 1'b0, 4, 3'b000, 1'b0};
    vecs[7]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 4, 3'b010, 1'b0};
    vecs[8]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b010, 1'b0};
    vecs[9]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4, 3'b001, 1'b0};
    vecs[10] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0};
    vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b000, 1'b1};
    vecs[12] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b000, 1'b0};
    vecs[13] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 1'b0};
    vecs[14] = '{7'b0000000, 3'b000, 1'b0, 1'b1, 2, 3'b000, 1'b0};

    bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.zero = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",     16'(bus.state),     16'd0);
    chk("rst_PC_write",  16'(bus.PC_write),  16'd0);
    chk("rst_IR_write",  16'(bus.IR_write),  16'd0);
    chk("rst_mem_write", 16'(bus.mem_write), 16'd0);
    chk("rst_reg_write", 16'(bus.reg_write), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, lat, alu_x, pcw);
      chk($sformatf("vec%0d_lat", i), 16'(lat), 16'(vecs[i].lat));
      chk($sformatf("vec%0d_alu", i), 16'(alu_x), 16'(vecs[i].alu));
      chk($sformatf("vec%0d_pcw_last", i), 16'(pcw), 16'(vecs[i].pcw));
    end

    // Reset asserted between clock edges while a store is in MEMWRITE.
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.state == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("memwrite_reached", 16'(found), 16'd1);
    chk("memwrite_strobe",  16'(bus.mem_write), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", 16'(bus.mem_write), 16'd0);
    chk("async_rst_state",     16'(bus.state),     16'd0);
    chk("async_rst_PC_write",  16'(bus.PC_write),  16'd0);
    chk("async_rst_IR_write",  16'(bus.IR_write),  16'd0);
    @(posedge clk);
    #1;
    chk("held_rst_state",     16'(bus.state),     16'd0);
    chk("held_rst_IR_write",  16'(bus.IR_write),  16'd0);
    chk("held_rst_reg_write", 16'(bus.reg_write), 16'd0);
    rst_n = 1'b1;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, lat, alu_x, pcw);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       o = 7'b0000011;
        1:       o = 7'b0100011;
        2:       o = 7'b0110011;
        3:       o = 7'b0010011;
        4:       o = 7'b1101111;
        5:       o = 7'b1100011;
        default: o = 7'($urandom);
      endcase
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), lat, alu_x, pcw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
